// File: rtl/cnn_dot_mac_ctrl_if.sv
// Block-level control (ap_ctrl_hs) plus activation/weight BRAM port bundle for cnn_dot_mac_ctrl.
// Latency: none, wiring only; backpressure: none, BRAM ports are fixed one-cycle read latency.
interface cnn_dot_mac_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int OUT_W  = 14
);
    logic              ap_start;
    logic              ap_idle;
    logic              ap_ready;
    logic              ap_done;
    logic [ADDR_W-1:0] len;
    logic [13:0]       bias;
    logic [ADDR_W-1:0] a_address0;
    logic              a_ce0;
    logic [7:0]        a_q0;
    logic [ADDR_W-1:0] w_address0;
    logic              w_ce0;
    logic [13:0]       w_q0;
    logic [OUT_W-1:0]  result;
    logic              sat_flag;

    modport slave (
        input  ap_start, len, bias, a_q0, w_q0,
        output ap_idle, ap_ready, ap_done, a_address0, a_ce0, w_address0, w_ce0, result, sat_flag
    );

    modport master (
        output ap_start, len, bias, a_q0, w_q0,
        input  ap_idle, ap_ready, ap_done, a_address0, a_ce0, w_address0, w_ce0, result, sat_flag
    );
endinterface

// File: rtl/cnn_dot_mac_ctrl.sv
// Dot-product sequencer: int8 x ap_fixed<14,6> MAC over L BRAM elements, saturated to ap_fixed<14,6>.
// Latency: start edge to ap_done is L+4 cycles (2 for L=0); no backpressure, the pipeline never stalls.
module cnn_dot_mac_ctrl #(
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 14
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    cnn_dot_mac_ctrl_if.slave   bus
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int PROD_W = 22;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_inc;
    logic [ADDR_W-1:0]         len_q;
    logic                      d_vld;
    logic                      p_vld;
    logic signed [PROD_W-1:0]  a_s;
    logic signed [PROD_W-1:0]  w_s;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc;
    logic                      ready_q;
    logic                      done_q;
    logic                      sat_q;
    logic [OUT_W-1:0]          result_q;
    logic                      start_acc;
    logic                      last_issue;
    logic                      ce;
    logic [ADDR_W-1:0]         addr;
    logic                      idle;

    // Counter is one bit wider than the address so a 2^ADDR_W-1 run never wraps.
    assign cnt_inc    = cnt + CNT_W'(1);
    assign last_issue = (cnt_inc == {1'b0, len_q});
    assign start_acc  = (state == IDLE) && bus.ap_start;
    assign a_s        = PROD_W'($signed(bus.a_q0));
    assign w_s        = PROD_W'($signed(bus.w_q0));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle      = 1'b0;
        ce        = 1'b0;
        addr      = '0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (bus.ap_start) begin
                    state_nxt = (bus.len == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                ce   = 1'b1;
                addr = cnt[ADDR_W-1:0];
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // p_vld clearing means the final product has been added into acc.
                if (!d_vld && !p_vld) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt      <= '0;
            len_q    <= '0;
            d_vld    <= 1'b0;
            p_vld    <= 1'b0;
            prod     <= '0;
            acc      <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            ready_q <= start_acc;
            done_q  <= (state == DONE);
            d_vld   <= (state == ISSUE);
            p_vld   <= d_vld;
            if (d_vld) begin
                prod <= a_s * w_s;
            end
            if (start_acc) begin
                len_q <= bus.len;
                cnt   <= '0;
                acc   <= ACC_W'($signed(bus.bias));
            end else begin
                if (state == ISSUE) begin
                    cnt <= cnt_inc;
                end
                if (p_vld) begin
                    acc <= acc + ACC_W'(prod);
                end
            end
            if (state == DONE) begin
                if (acc > SAT_MAX) begin
                    result_q <= SAT_MAX[OUT_W-1:0];
                    sat_q    <= 1'b1;
                end else if (acc < SAT_MIN) begin
                    result_q <= SAT_MIN[OUT_W-1:0];
                    sat_q    <= 1'b1;
                end else begin
                    result_q <= acc[OUT_W-1:0];
                    sat_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.ap_idle    = idle;
    assign bus.ap_ready   = ready_q;
    assign bus.ap_done    = done_q;
    assign bus.a_ce0      = ce;
    assign bus.w_ce0      = ce;
    assign bus.a_address0 = addr;
    assign bus.w_address0 = addr;
    assign bus.result     = result_q;
    assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_cnn_dot_mac_ctrl.sv
// Self-checking bench for cnn_dot_mac_ctrl: vector table, hand sequences, randomized runs vs a dot-product model.
// Latency: checks exact start-to-done cycle counts; backpressure: none, BRAMs modelled with one-cycle reads.
module tb_cnn_dot_mac_ctrl;
    localparam int ADDR_W = 10;
    localparam int ACC_W  = 32;
    localparam int OUT_W  = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    cnn_dot_mac_ctrl_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

    cnn_dot_mac_ctrl #(.ADDR_W(ADDR_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    logic [7:0]  a_mem [DEPTH];
    logic [13:0] w_mem [DEPTH];

    always @(posedge ap_clk) begin
        if (bus.a_ce0) bus.a_q0 <= a_mem[bus.a_address0];
        if (bus.w_ce0) bus.w_q0 <= w_mem[bus.w_address0];
    end

    int issue_cnt [DEPTH];
    int ce_total  = 0;
    int oob       = 0;
    int addr_mis  = 0;
    int ready_cnt = 0;
    int done_cnt  = 0;
    int cur_len   = 0;

    always @(negedge ap_clk) begin
        if (bus.a_ce0) begin
            issue_cnt[bus.a_address0] = issue_cnt[bus.a_address0] + 1;
            ce_total = ce_total + 1;
            if (int'(bus.a_address0) >= cur_len) oob = oob + 1;
        end
        if (bus.a_ce0 !== bus.w_ce0 || (bus.a_ce0 && bus.a_address0 !== bus.w_address0))
            addr_mis = addr_mis + 1;
        if (bus.ap_ready) ready_cnt = ready_cnt + 1;
        if (bus.ap_done)  done_cnt  = done_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact integer dot product plus bias, then clamp to the 14-bit signed range.
    function automatic longint model_sum(input int len, input int b);
        longint s = longint'(b);
        for (int i = 0; i < len; i++)
            s += longint'($signed(a_mem[i])) * longint'($signed(w_mem[i]));
        return s;
    endfunction

    function automatic longint clamp(input longint s);
        if (s > 8191) return 8191;
        if (s < -8192) return -8192;
        return s;
    endfunction

    task automatic do_run(input int len, input int b, input longint er, input longint es, input string tag);
        int base [DEPTH];
        int ce0, oob0, mis0, rdy0, lat, bad;
        foreach (base[i]) base[i] = issue_cnt[i];
        ce0 = ce_total; oob0 = oob; mis0 = addr_mis; rdy0 = ready_cnt;
        @(negedge ap_clk);
        cur_len = len;
        bus.len = ADDR_W'(len);
        bus.bias = 14'(b);
        bus.ap_start = 1'b1;
        @(posedge ap_clk); #1;
        bus.ap_start = 1'b0;
        bus.len = ADDR_W'($urandom);
        bus.bias = 14'($urandom);
        check({tag, "_ready"}, longint'(bus.ap_ready), 1);
        lat = -1;
        for (int k = 1; k <= len + 50; k++) begin
            @(posedge ap_clk); #1;
            if (bus.ap_done) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, (len == 0) ? 2 : len + 4);
        check({tag, "_result"}, longint'($signed(bus.result)), er);
        check({tag, "_sat"}, longint'(bus.sat_flag), es);
        @(posedge ap_clk); #1;
        check({tag, "_done_pulse"}, longint'(bus.ap_done), 0);
        @(negedge ap_clk);
        check({tag, "_ready_count"}, ready_cnt - rdy0, 1);
        check({tag, "_ce_count"}, ce_total - ce0, len);
        check({tag, "_addr_range"}, oob - oob0, 0);
        check({tag, "_addr_match"}, addr_mis - mis0, 0);
        bad = 0;
        for (int i = 0; i < len; i++)
            if (issue_cnt[i] - base[i] != 1) bad++;
        check({tag, "_addr_once"}, bad, 0);
    endtask

    typedef struct packed {
        logic [10:0]        len;
        logic signed [15:0] bias;
        logic [7:0][7:0]    a;
        logic [7:0][13:0]   w;
        logic signed [15:0] exp_res;
        logic               exp_sat;
    } vec_t;

    function automatic vec_t mk(input int len, input int b, input int ac, input int wc, input int er, input bit es);
        vec_t v;
        v.len = 11'(len);
        v.bias = 16'(b);
        for (int i = 0; i < 8; i++) begin
            v.a[i] = 8'(ac);
            v.w[i] = 14'(wc);
        end
        v.exp_res = 16'(er);
        v.exp_sat = es;
        return v;
    endfunction

    vec_t tbl [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b1, b2, lat1, lat2, rdy0, done0, len, b;
        longint s, r1, r2;
        logic [13:0] braw;

        foreach (issue_cnt[i]) issue_cnt[i] = 0;
        foreach (a_mem[i]) begin
            a_mem[i] = 8'(i);
            w_mem[i] = 14'(i);
        end
        bus.ap_start = 1'b0;
        bus.len = '0;
        bus.bias = '0;

        tbl[0] = mk(4, 0, 0, 256, 1024, 1'b0);
        tbl[0].a[0] = 8'd1; tbl[0].a[1] = 8'd2; tbl[0].a[2] = 8'hFD; tbl[0].a[3] = 8'd4;
        tbl[1] = mk(3, 0, 127, 8191, 8191, 1'b1);
        tbl[2] = mk(2, -100, -128, 8191, -8192, 1'b1);
        tbl[3] = mk(0, -37, 0, 0, -37, 1'b0);
        tbl[4] = mk(1, 0, 2, 256, 512, 1'b0);
        tbl[5] = mk(2, 5, 0, 0, 561, 1'b0);
        tbl[5].a[0] = 8'hFF; tbl[5].w[0] = 14'h3F00; tbl[5].a[1] = 8'd3; tbl[5].w[1] = 14'd100;
        tbl[6] = mk(1, 0, -32, 256, -8192, 1'b0);
        tbl[7] = mk(1, 8191, 1, 1, 8191, 1'b1);
        tbl[8] = mk(8, -8192, -1, -1, -8184, 1'b0);

        // Reset state
        #2;
        check("rst_idle", longint'(bus.ap_idle), 1);
        check("rst_ready", longint'(bus.ap_ready), 0);
        check("rst_done", longint'(bus.ap_done), 0);
        check("rst_ce", longint'(bus.a_ce0 | bus.w_ce0), 0);
        check("rst_addr", longint'(bus.a_address0 | bus.w_address0), 0);
        check("rst_result", longint'(bus.result), 0);
        check("rst_sat", longint'(bus.sat_flag), 0);
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);

        for (int n = 0; n < 9; n++) begin
            for (int i = 0; i < 8; i++) begin
                a_mem[i] = tbl[n].a[i];
                w_mem[i] = tbl[n].w[i];
            end
            do_run(int'(tbl[n].len), int'(tbl[n].bias), longint'(tbl[n].exp_res),
                   longint'(tbl[n].exp_sat), $sformatf("vec%0d", n));
        end

        // Back-to-back with ap_start held high; new len/bias presented after the first ready
        a_mem[0] = 8'd3;   w_mem[0] = 14'd100;
        a_mem[1] = 8'hFE;  w_mem[1] = 14'h3FCE;
        a_mem[2] = 8'd5;   w_mem[2] = 14'd256;
        a_mem[3] = 8'd1;   w_mem[3] = 14'd10;
        a_mem[4] = 8'd7;   w_mem[4] = 14'h3FFD;
        b1 = 20; b2 = -1000;
        r1 = clamp(model_sum(2, b1));
        r2 = clamp(model_sum(5, b2));
        rdy0 = ready_cnt;
        @(negedge ap_clk);
        cur_len = 5;
        bus.len = ADDR_W'(2);
        bus.bias = 14'(b1);
        bus.ap_start = 1'b1;
        @(posedge ap_clk); #1;
        check("b2b_ready1", longint'(bus.ap_ready), 1);
        bus.len = ADDR_W'(5);
        bus.bias = 14'(b2);
        lat1 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge ap_clk); #1;
            if (bus.ap_done) begin lat1 = k; break; end
        end
        check("b2b_latency1", lat1, 6);
        check("b2b_result1", longint'($signed(bus.result)), r1);
        lat2 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge ap_clk); #1;
            if (bus.ap_done) begin lat2 = k; break; end
        end
        bus.ap_start = 1'b0;
        check("b2b_latency2", lat2, 10);
        check("b2b_result2", longint'($signed(bus.result)), r2);
        @(posedge ap_clk); #1;
        @(negedge ap_clk);
        check("b2b_ready_count", ready_cnt - rdy0, 2);
        check("b2b_idle_after", longint'(bus.ap_idle), 1);

        // Reset during ISSUE of an L=10 run
        for (int i = 0; i < 10; i++) begin
            a_mem[i] = 8'($urandom);
            w_mem[i] = 14'($urandom);
        end
        done0 = done_cnt;
        @(negedge ap_clk);
        cur_len = 10;
        bus.len = ADDR_W'(10);
        bus.bias = 14'd0;
        bus.ap_start = 1'b1;
        @(posedge ap_clk); #1;
        bus.ap_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("midrst_busy", longint'(bus.a_ce0), 1);
        ap_rst_n = 1'b0;
        #1;
        check("midrst_idle", longint'(bus.ap_idle), 1);
        check("midrst_ready", longint'(bus.ap_ready), 0);
        check("midrst_ce", longint'(bus.a_ce0 | bus.w_ce0), 0);
        check("midrst_addr", longint'(bus.a_address0 | bus.w_address0), 0);
        check("midrst_result", longint'(bus.result), 0);
        check("midrst_sat", longint'(bus.sat_flag), 0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (16) @(negedge ap_clk);
        check("midrst_no_done", done_cnt - done0, 0);
        a_mem[0] = 8'd2;
        w_mem[0] = 14'd256;
        do_run(1, 0, 512, 0, "after_rst");

        // Randomized runs against the model
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(0, 24);
            braw = 14'($urandom);
            b = int'($signed(braw));
            for (int i = 0; i < len; i++) begin
                a_mem[i] = 8'($urandom);
                w_mem[i] = (r % 2 == 0) ? 14'($urandom) : 14'($urandom_range(0, 511) - 256);
            end
            s = model_sum(len, b);
            do_run(len, b, clamp(s), longint'(s != clamp(s)), $sformatf("rnd%0d", r));
        end

        // Maximum length run
        len = DEPTH - 1;
        for (int i = 0; i < len; i++) begin
            a_mem[i] = 8'($urandom);
            w_mem[i] = 14'($urandom_range(0, 63) - 32);
        end
        braw = 14'($urandom);
        b = int'($signed(braw));
        s = model_sum(len, b);
        do_run(len, b, clamp(s), longint'(s != clamp(s)), "maxlen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
